// File: rtl/fifo16_ctrl_if.sv
// fifo16_ctrl_if: producer/consumer handshake bundle for fifo16_ctrl.
//   master: push/push_data/pop/clr_err out; pop_data/pop_valid/full/empty/count/overflow/underflow in.
//   slave:  the controller side, directions mirrored.
interface fifo16_ctrl_if #(parameter int WIDTH = 16, parameter int AW = 4);
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;
  modport master (output push, push_data, pop, clr_err,
                  input  pop_data, pop_valid, full, empty, count, overflow, underflow);
  modport slave  (input  push, push_data, pop, clr_err,
                  output pop_data, pop_valid, full, empty, count, overflow, underflow);
endinterface

// File: rtl/fifo16_ctrl.sv
// fifo16_ctrl: FIFO controller for a 16x16 dual-port negedge SRAM.
//   clk, rst_n : posedge clock, asynchronous active-low reset
//   f          : push/pop handshake, occupancy and sticky error flags (slave modport)
//   mem_*      : SRAM strobes/addresses/data; SRAM samples them on the negedge of the same cycle
module fifo16_ctrl #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo16_ctrl_if.slave     f,
  output logic             mem_we,
  output logic             mem_re,
  output logic [AW-1:0]    mem_waddr,
  output logic [AW-1:0]    mem_raddr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);
  localparam logic [AW:0] depth = {1'b1, {AW{1'b0}}};
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          full, empty, do_push, do_pop;
  assign full    = cnt == depth;
  assign empty   = cnt == '0;
  assign do_pop  = f.pop & ~empty;
  // a pop in the same cycle frees the slot, so push is accepted even when full
  assign do_push = f.push & (~full | do_pop);
  assign mem_we    = do_push;
  assign mem_waddr = wptr;
  assign mem_wdata = f.push_data;
  assign mem_re    = do_pop;
  assign mem_raddr = rptr;
  assign f.full    = full;
  assign f.empty   = empty;
  assign f.count   = cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      cnt         <= '0;
      f.pop_valid <= 1'b0;
      f.pop_data  <= '0;
      f.overflow  <= 1'b0;
      f.underflow <= 1'b0;
    end else begin
      wptr        <= wptr + AW'(do_push);
      rptr        <= rptr + AW'(do_pop);
      cnt         <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      f.pop_valid <= do_pop;
      // mem_rdata was refreshed by the SRAM at this cycle's negedge
      if (do_pop) f.pop_data <= mem_rdata;
      f.overflow  <= (f.push & full & ~f.pop) | (f.overflow & ~f.clr_err);
      f.underflow <= (f.pop & empty) | (f.underflow & ~f.clr_err);
    end
  end
endmodule
